// File: rtl/if_stage.sv
`default_nettype none
// ============================================================================
// Module   : if_stage
// Brief    : Instruction fetch stage. Owns the fetch PC, issues word requests
//            over a req/gnt/rvalid bus, buffers returned words in a small
//            FIFO and hands {pc, instr} pairs to decode with valid/ready.
//            Redirects flush the FIFO and discard in-flight responses.
//            Optional feature macro: IF_ALIGN_CHECK_EN (misaligned redirect
//            detection with a HALT state).
// Revision : 1.0 - initial release
// ============================================================================
module if_stage #(
  parameter logic [31:0] BOOT_ADDR  = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        instr_req_o,
  output logic [31:0] instr_addr_o,
  input  logic        instr_gnt_i,
  input  logic        instr_rvalid_i,
  input  logic [31:0] instr_rdata_i,
  output logic        instr_valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  input  logic        instr_ready_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_addr_i,
  output logic        misaligned_o
);

  localparam int               c_cnt_w = $clog2(FIFO_DEPTH + 1);
  localparam int               c_ptr_w = $clog2(FIFO_DEPTH);
  localparam logic [c_cnt_w:0] c_depth = (c_cnt_w + 1)'(FIFO_DEPTH);

`ifdef IF_ALIGN_CHECK_EN
  typedef enum logic [1:0] {
    ST_RESET = 2'd0,
    ST_FETCH = 2'd1,
    ST_HALT  = 2'd2
  } state_t;
`else
  typedef enum logic [0:0] {
    ST_RESET = 1'b0,
    ST_FETCH = 1'b1
  } state_t;
`endif

  state_t              r_state;
  state_t              w_state_next;

  logic [31:0]         r_fetch_addr;
  logic [31:0]         r_hold_addr;
  logic [31:0]         r_resp_pc;
  logic                r_hold;
  logic                r_stale;

  logic [c_cnt_w-1:0]  r_outstanding;
  logic [c_cnt_w-1:0]  r_drop_cnt;
  logic [c_cnt_w-1:0]  r_count;
  logic [c_cnt_w-1:0]  w_out_next;
  logic [c_cnt_w-1:0]  w_live;
  logic [c_cnt_w:0]    w_demand;

  logic [c_ptr_w-1:0]  r_wr_ptr;
  logic [c_ptr_w-1:0]  r_rd_ptr;
  logic [31:0]         r_fifo_pc    [FIFO_DEPTH];
  logic [31:0]         r_fifo_instr [FIFO_DEPTH];

  logic [31:0]         w_target;
  logic                w_grant;
  logic                w_stale_grant;
  logic                w_drop_resp;
  logic                w_push;
  logic                w_pop;
  logic                w_credit;

`ifdef IF_ALIGN_CHECK_EN
  logic                w_misaligned;
  logic                r_misaligned;

  assign w_target     = redirect_addr_i;
  assign w_misaligned = redirect_i & (redirect_addr_i[1:0] != 2'b00);
  assign misaligned_o = r_misaligned;
`else
  logic                w_unused_addr_bits;

  // Low target bits carry no meaning without the alignment check.
  assign w_target           = {redirect_addr_i[31:2], 2'b00};
  assign w_unused_addr_bits = ^redirect_addr_i[1:0];
  assign misaligned_o       = 1'b0;
`endif

  // FIFO head is visible directly from storage; a push only shows up the
  // cycle after the response edge, so there is no bypass path.
  assign instr_valid_o = (r_count != '0);
  assign instr_o       = r_fifo_instr[r_rd_ptr];
  assign pc_o          = r_fifo_pc[r_rd_ptr];
  assign w_pop         = instr_valid_o & instr_ready_i;

  // Credit: buffered entries (minus the one leaving now) plus responses that
  // will really be pushed must leave room for one more.
  assign w_live   = r_outstanding - r_drop_cnt;
  assign w_demand = (c_cnt_w + 1)'(r_count) - (c_cnt_w + 1)'(w_pop)
                  + (c_cnt_w + 1)'(w_live);
  assign w_credit = (w_demand < c_depth);

  // A started request is held with its address until granted, regardless of
  // redirects or state changes.
  assign instr_req_o  = r_hold | ((r_state == ST_FETCH) & w_credit);
  assign instr_addr_o = r_hold ? r_hold_addr : r_fetch_addr;

  assign w_grant       = instr_req_o & instr_gnt_i;
  assign w_stale_grant = w_grant & r_hold & r_stale;
  assign w_drop_resp   = instr_rvalid_i & (r_drop_cnt != '0);
  assign w_push        = instr_rvalid_i & ~w_drop_resp & ~redirect_i;
  assign w_out_next    = r_outstanding + c_cnt_w'(w_grant)
                       - c_cnt_w'(instr_rvalid_i);

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= ST_RESET;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic: leave RESET once, optionally park in HALT on a bad target.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_RESET: w_state_next = ST_FETCH;
      ST_FETCH: begin
`ifdef IF_ALIGN_CHECK_EN
        if (w_misaligned) begin
          w_state_next = ST_HALT;
        end
`else
        w_state_next = ST_FETCH;
`endif
      end
`ifdef IF_ALIGN_CHECK_EN
      ST_HALT: begin
        if (redirect_i && !w_misaligned) begin
          w_state_next = ST_FETCH;
        end
      end
`endif
      default: w_state_next = ST_RESET;
    endcase
  end

  // Fetch address and held-request tracking; a held request overtaken by a
  // redirect is marked stale so its grant neither advances the PC nor goes live.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_fetch_addr <= BOOT_ADDR;
      r_hold       <= 1'b0;
      r_hold_addr  <= BOOT_ADDR;
      r_stale      <= 1'b0;
    end else begin
      if (redirect_i) begin
        r_fetch_addr <= w_target;
      end else if (w_grant && !(r_hold && r_stale)) begin
        r_fetch_addr <= r_fetch_addr + 32'd4;
      end
      r_hold <= instr_req_o & ~instr_gnt_i;
      if (instr_req_o && !instr_gnt_i) begin
        r_hold_addr <= instr_addr_o;
        r_stale     <= (r_hold & r_stale) | redirect_i;
      end else begin
        r_stale     <= 1'b0;
      end
    end
  end

  // Outstanding/drop counters: a redirect turns everything in flight into drops.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_outstanding <= '0;
      r_drop_cnt    <= '0;
    end else begin
      r_outstanding <= w_out_next;
      if (redirect_i) begin
        r_drop_cnt <= w_out_next;
      end else begin
        r_drop_cnt <= r_drop_cnt + c_cnt_w'(w_stale_grant)
                    - c_cnt_w'(w_drop_resp);
      end
    end
  end

  // Address to tag the next live response with.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_resp_pc <= BOOT_ADDR;
    end else if (redirect_i) begin
      r_resp_pc <= w_target;
    end else if (w_push) begin
      r_resp_pc <= r_resp_pc + 32'd4;
    end
  end

  // Instruction buffer; a redirect empties it and wins over a same-cycle pop.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_fifo_pc[i]    <= '0;
        r_fifo_instr[i] <= '0;
      end
    end else if (redirect_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_fifo_pc[r_wr_ptr]    <= r_resp_pc;
        r_fifo_instr[r_wr_ptr] <= instr_rdata_i;
        r_wr_ptr               <= r_wr_ptr + c_ptr_w'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
      end
      r_count <= r_count + c_cnt_w'(w_push) - c_cnt_w'(w_pop);
    end
  end

`ifdef IF_ALIGN_CHECK_EN
  // One-cycle flag following a redirect to a non-word-aligned target.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_misaligned <= 1'b0;
    end else begin
      r_misaligned <= w_misaligned;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_if_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_if_stage
// Brief    : Self-checking bench for if_stage: directed cycle table, reset,
//            backpressure and randomized traffic against a stream model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_if_stage;

  localparam logic [31:0] BOOT  = 32'h0000_0100;
  localparam int          DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_req;
  logic [31:0] instr_addr;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] pc;
  logic        ready;
  logic        redirect;
  logic [31:0] raddr;
  logic        misaligned;

  always #5 clk = ~clk;

  if_stage #(.BOOT_ADDR(BOOT), .FIFO_DEPTH(DEPTH)) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .instr_req_o     (instr_req),
    .instr_addr_o    (instr_addr),
    .instr_gnt_i     (gnt),
    .instr_rvalid_i  (rvalid),
    .instr_rdata_i   (rdata),
    .instr_valid_o   (instr_valid),
    .instr_o         (instr),
    .pc_o            (pc),
    .instr_ready_i   (ready),
    .redirect_i      (redirect),
    .redirect_addr_i (raddr),
    .misaligned_o    (misaligned)
  );

  int tests = 0;
  int fails = 0;

  // Memory model: in-order queue of granted addresses with grant cycle.
  typedef struct {
    logic [31:0] addr;
    int          cyc;
  } mreq_t;
  mreq_t       mq[$];

  // Stream model: next pc decode should see, plus handshake bookkeeping.
  logic [31:0] exp_pc;
  logic [31:0] prev_addr;
  logic        prev_stall;
  int          cyc_no   = 0;
  int          grants   = 0;
  int          accepted = 0;

  typedef struct {
    logic        gnt;
    logic        rv;
    logic [31:0] rv_addr;
    logic        rdy;
    logic        redir;
    logic [31:0] tgt;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_pc;
  } vec_t;

  vec_t vt [33];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  function automatic vec_t mk(input int g, input int rv, input logic [31:0] rva,
                              input int rdy, input int rd, input logic [31:0] tgt,
                              input int er, input logic [31:0] ea,
                              input int ev, input logic [31:0] ep);
    vec_t v;
    v.gnt = 1'(g);  v.rv = 1'(rv);   v.rv_addr = rva;
    v.rdy = 1'(rdy); v.redir = 1'(rd); v.tgt = tgt;
    v.e_req = 1'(er); v.e_addr = ea; v.e_valid = 1'(ev); v.e_pc = ep;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic apply_reset(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rst = 1'b1; gnt = 1'b0; rvalid = 1'b0; rdata = '0;
      ready = 1'b0; redirect = 1'b0; raddr = '0;
    end
    mq.delete();
    exp_pc     = BOOT;
    prev_stall = 1'b0;
  endtask

  // One cycle of model-driven traffic with stream and protocol checks.
  task automatic step(input logic g, input logic rdy, input logic redir,
                      input logic [31:0] tgt, input int rv_pct);
    @(negedge clk);
    rst = 1'b0; gnt = g; ready = rdy; redirect = redir; raddr = tgt;
    if (mq.size() > 0 && mq[0].cyc < cyc_no && $urandom_range(1, 100) <= rv_pct) begin
      rvalid = 1'b1;
      rdata  = mem_word(mq[0].addr);
      void'(mq.pop_front());
    end else begin
      rvalid = 1'b0;
      rdata  = $urandom;
    end
    #1;
    if (prev_stall) begin
      check("req_hold", 32'(instr_req), 32'd1);
      check("addr_hold", instr_addr, prev_addr);
    end
    check("misaligned", 32'(misaligned), 32'd0);
    if (instr_req && g) begin
      mq.push_back('{addr: instr_addr, cyc: cyc_no});
      grants++;
    end
    if (instr_valid && rdy) begin
      check("pc", pc, exp_pc);
      check("instr", instr, mem_word(exp_pc));
      exp_pc = exp_pc + 32'd4;
      accepted++;
    end
    if (redir) exp_pc = tgt & 32'hFFFF_FFFC;
    prev_stall = instr_req && !g;
    prev_addr  = instr_addr;
    cyc_no++;
  endtask

  initial begin
    int g0;
    int a0;

    // gnt rv rv_addr rdy redir tgt | req addr valid pc
    vt[0]  = mk(1,0,0,       1,0,0,        0,0,        0,0);
    vt[1]  = mk(1,0,0,       1,0,0,        1,32'h100,  0,0);
    vt[2]  = mk(1,1,32'h100, 1,0,0,        1,32'h104,  0,0);
    vt[3]  = mk(1,1,32'h104, 1,0,0,        1,32'h108,  1,32'h100);
    vt[4]  = mk(1,1,32'h108, 1,0,0,        1,32'h10C,  1,32'h104);
    vt[5]  = mk(0,1,32'h10C, 0,0,0,        0,0,        1,32'h108);
    vt[6]  = mk(1,0,0,       0,0,0,        0,0,        1,32'h108);
    vt[7]  = mk(1,0,0,       1,0,0,        1,32'h110,  1,32'h108);
    vt[8]  = mk(1,0,0,       1,0,0,        1,32'h114,  1,32'h10C);
    vt[9]  = mk(1,0,0,       1,1,32'h200,  0,0,        0,0);
    vt[10] = mk(1,1,32'h110, 1,0,0,        1,32'h200,  0,0);
    vt[11] = mk(1,1,32'h114, 1,0,0,        1,32'h204,  0,0);
    vt[12] = mk(1,1,32'h200, 1,0,0,        0,0,        0,0);
    vt[13] = mk(1,1,32'h204, 1,0,0,        1,32'h208,  1,32'h200);
    vt[14] = mk(0,0,0,       1,0,0,        1,32'h20C,  1,32'h204);
    vt[15] = mk(0,1,32'h208, 1,1,32'h40,   1,32'h20C,  0,0);
    vt[16] = mk(0,0,0,       1,0,0,        1,32'h20C,  0,0);
    vt[17] = mk(1,0,0,       1,0,0,        1,32'h20C,  0,0);
    vt[18] = mk(1,1,32'h20C, 1,0,0,        1,32'h40,   0,0);
    vt[19] = mk(0,1,32'h40,  1,0,0,        1,32'h44,   0,0);
    vt[20] = mk(0,0,0,       1,0,0,        1,32'h44,   1,32'h40);
    vt[21] = mk(1,0,0,       0,0,0,        1,32'h44,   0,0);
    vt[22] = mk(0,1,32'h44,  0,0,0,        1,32'h48,   0,0);
    vt[23] = mk(1,0,0,       0,0,0,        1,32'h48,   1,32'h44);
    vt[24] = mk(0,1,32'h48,  1,1,32'h80,   1,32'h4C,   1,32'h44);
    vt[25] = mk(1,0,0,       1,0,0,        1,32'h4C,   0,0);
    vt[26] = mk(1,1,32'h4C,  1,0,0,        1,32'h80,   0,0);
    vt[27] = mk(0,1,32'h80,  1,0,0,        1,32'h84,   0,0);
    vt[28] = mk(0,0,0,       1,0,0,        1,32'h84,   1,32'h80);
    vt[29] = mk(1,0,0,       1,1,32'h302,  1,32'h84,   0,0);
    vt[30] = mk(1,1,32'h84,  1,0,0,        1,32'h300,  0,0);
    vt[31] = mk(0,1,32'h300, 1,0,0,        1,32'h304,  0,0);
    vt[32] = mk(0,0,0,       1,0,0,        1,32'h304,  1,32'h300);

    apply_reset(2);
    #1;
    check("rst_req", 32'(instr_req), 32'd0);
    check("rst_addr", instr_addr, BOOT);
    check("rst_valid", 32'(instr_valid), 32'd0);

    // Directed cycle table: sequential fetch, backpressure, redirects,
    // stalled grant with redirect, pop+redirect+rvalid, unaligned target.
    for (int i = 0; i < 33; i++) begin
      @(negedge clk);
      rst      = 1'b0;
      gnt      = vt[i].gnt;
      rvalid   = vt[i].rv;
      rdata    = vt[i].rv ? mem_word(vt[i].rv_addr) : 32'd0;
      ready    = vt[i].rdy;
      redirect = vt[i].redir;
      raddr    = vt[i].tgt;
      #1;
      check($sformatf("row%0d_req", i), 32'(instr_req), 32'(vt[i].e_req));
      if (vt[i].e_req) check($sformatf("row%0d_addr", i), instr_addr, vt[i].e_addr);
      check($sformatf("row%0d_valid", i), 32'(instr_valid), 32'(vt[i].e_valid));
      if (vt[i].e_valid) begin
        check($sformatf("row%0d_pc", i), pc, vt[i].e_pc);
        check($sformatf("row%0d_instr", i), instr, mem_word(vt[i].e_pc));
      end
      check($sformatf("row%0d_misaligned", i), 32'(misaligned), 32'd0);
    end

    // Reset in the middle of operation returns every output to reset values.
    @(negedge clk);
    rst = 1'b1; gnt = 1'b0; rvalid = 1'b0; ready = 1'b0; redirect = 1'b0;
    @(negedge clk);
    #1;
    check("mid_rst_req", 32'(instr_req), 32'd0);
    check("mid_rst_addr", instr_addr, BOOT);
    check("mid_rst_valid", 32'(instr_valid), 32'd0);
    check("mid_rst_pc", pc, 32'd0);
    check("mid_rst_instr", instr, 32'd0);
    check("mid_rst_misaligned", 32'(misaligned), 32'd0);

    // Backpressure: decode stalled, only FIFO_DEPTH requests may go out.
    apply_reset(1);
    g0 = grants;
    for (int i = 0; i < 12; i++) step(1'b1, 1'b0, 1'b0, 32'd0, 100);
    check("bp_grants", 32'(grants - g0), 32'(DEPTH));
    check("bp_req_off", 32'(instr_req), 32'd0);
    check("bp_valid", 32'(instr_valid), 32'd1);
    check("bp_pc", pc, BOOT);
    check("bp_instr", instr, mem_word(BOOT));
    for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1'b0, 32'd0, 100);
    check("bp_drain", 32'(exp_pc >= BOOT + 32'd16), 32'd1);

    // Randomized traffic checked against the pc/instr stream model.
    apply_reset(2);
    a0 = accepted;
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 99) < 70, $urandom_range(0, 99) < 70,
           $urandom_range(0, 99) < 3, $urandom & 32'h0000_FFFF, 60);
    end
    check("progress", 32'(accepted - a0 > 300), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
